// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared state encodings, widths and grant helper for the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int   WIDTH = 16;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_e;

  // IF takes the port when it is alone or when D has starved it long enough.
  function automatic logic if_wins(input logic if_req, input logic d_req,
                                   input logic starve_full);
    return if_req & (~d_req | starve_full);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Requester (IF / D) handshakes and the shared memory-port bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = WIDTH,
  parameter int DW = WIDTH
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          if_err;

  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          stall;

  logic          mem_cs;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_valid, if_rdata, if_err, d_valid, d_rdata, d_err, stall,
           mem_cs, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_valid, if_rdata, if_err, d_valid, d_rdata, d_err, stall,
           mem_cs, mem_rw, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// ============================================================================
// Module : mem_arb_timer
// Brief  : Busy-cycle counter; expire fires on the enabled edge reaching TIMEOUT.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_timer #(
  parameter int TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic res,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts edges already spent, so the TIMEOUT-th edge sees TIMEOUT-1.
  assign expire = enable & (cnt_q == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between IF and D with IF starvation guard
//          and a response timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = WIDTH,
  parameter int DW           = WIDTH,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  wire logic          clk,
  input  wire logic          res,
  mem_port_arbiter_if.slave  bus
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_valid_q, if_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          if_err_q, if_err_d;
  logic          d_valid_q, d_valid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_err_q, d_err_d;

  logic          idle, busy, grant_if, grant_d, mem_done, tmr_expire;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  assign idle     = (state_q == ARB_IDLE);
  assign busy     = ~idle;
  assign grant_if = idle & if_wins(bus.if_req, bus.d_req, starve_q == STARVE_MAX);
  assign grant_d  = idle & bus.d_req & ~grant_if;
  assign mem_done = busy & (bus.mem_ready | tmr_expire);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .res    (res),
    .clear  (idle),
    .enable (busy & ~bus.mem_ready),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      mem_cs_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_cs_q    <= mem_cs_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_if) begin
          state_d = ARB_IF;
        end else if (grant_d) begin
          state_d = ARB_D;
        end
      end
      ARB_IF, ARB_D: begin
        if (mem_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    starve_d    = starve_q;
    mem_cs_d    = mem_cs_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = 1'b0;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;
    // A timed-out access returns zero data; a write never returns data.
    rsp_data    = (bus.mem_ready & mem_rw_q) ? bus.mem_rdata : '0;
    rsp_err     = ~bus.mem_ready;

    if (grant_if) begin
      mem_cs_d    = 1'b1;
      mem_rw_d    = 1'b1;
      mem_addr_d  = bus.if_addr;
      mem_wdata_d = '0;
      starve_d    = '0;
    end else if (grant_d) begin
      mem_cs_d    = 1'b1;
      mem_rw_d    = bus.d_rw;
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
      if (!bus.if_req) begin
        starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + SW'(1);
      end
    end

    if (mem_done) begin
      mem_cs_d = 1'b0;
      if (state_q == ARB_IF) begin
        if_valid_d = 1'b1;
        if_rdata_d = rsp_data;
        if_err_d   = rsp_err;
      end else begin
        d_valid_d  = 1'b1;
        d_rdata_d  = rsp_data;
        d_err_d    = rsp_err;
      end
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.stall     = bus.d_req & ~d_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Vector table of single transactions plus starvation and reset
//          sequences, checked against a queue of expected responses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic        is_d;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    int          delay;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_port_arbiter #(
    .AW           (16),
    .DW           (16),
    .STARVE_LIMIT (3),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_cs) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("mem_cs_never_rose", 32'd0, 32'd1);
  endtask

  // One request, memory answers delay cycles after cs (never if delay >= TIMEOUT).
  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   ok;
    bit   stall_ok;
    int   lat;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_rw = v.rw; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    e.is_d  = v.is_d;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.lat   = (v.delay >= TIMEOUT) ? TIMEOUT : v.delay + 1;
    sb_q.push_back(e);
    bus.mem_rdata = v.mrdata;
    @(negedge clk);
    wait_cs(ok);
    if (ok) begin
      chk("mem_addr", bus.mem_addr, v.addr);
      chk("mem_rw", bus.mem_rw, v.is_d ? v.rw : 1'b1);
      chk("mem_wdata", bus.mem_wdata, v.is_d ? v.wdata : 16'h0);
      lat = 0; stall_ok = 1'b1; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (v.is_d && !bus.stall) stall_ok = 1'b0;
        if (i == v.delay && v.delay < TIMEOUT) bus.mem_ready = 1'b1;
        @(negedge clk);
        lat++;
        bus.mem_ready = 1'b0;
        if (bus.if_valid || bus.d_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        chk("valid_never_pulsed", 32'd0, 32'd1);
        sb_q.delete();
      end else begin
        e = sb_q.pop_front();
        chk("latency", lat, e.lat);
        chk("owner_valid", e.is_d ? bus.d_valid : bus.if_valid, 1'b1);
        chk("other_valid", e.is_d ? bus.if_valid : bus.d_valid, 1'b0);
        chk("rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
        chk("err", e.is_d ? bus.d_err : bus.if_err, e.err);
        chk("cs_low_after_done", bus.mem_cs, 1'b0);
        if (v.is_d) begin
          chk("stall_held", stall_ok, 1'b1);
          chk("stall_release", bus.stall, 1'b0);
        end
      end
    end else begin
      sb_q.delete();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    chk("valid_one_cycle", bus.if_valid | bus.d_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t v;
    bit   ord_q[$];
    bit   exp_d;
    bit   ok;
    bit   seen;

    //          is_d rw  addr      wdata     mrdata    delay rdata     err
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 2,  16'h1234, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h5555, 1,  16'h0000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0030, 16'h0000, 16'hA5A5, 0,  16'hA5A5, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'hFFFF, 99, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 16'h0050, 16'h0000, 16'h7777, 14, 16'h7777, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0060, 16'hC0DE, 16'h3333, 99, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 16'h0070, 16'h0000, 16'h2468, 13, 16'h2468, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0001, 3,  16'h0001, 1'b0};

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    res = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;

    chk("rst_mem_cs", bus.mem_cs, 1'b0);
    chk("rst_mem_rw", bus.mem_rw, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
    chk("rst_valids", {bus.if_valid, bus.d_valid}, 2'b00);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 32'h0);
    chk("rst_errs", {bus.if_err, bus.d_err}, 2'b00);
    chk("rst_stall", bus.stall, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters held: D wins until the starvation count saturates.
    ord_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.if_req = 1'b1; bus.if_addr = 16'h0100;
    bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = 16'h0200;
    bus.mem_rdata = 16'h0F0F;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      wait_cs(ok);
      if (!ok) break;
      exp_d = ord_q.pop_front();
      chk("grant_owner", bus.mem_addr, exp_d ? 16'h0200 : 16'h0100);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("grant_valid", exp_d ? bus.d_valid : bus.if_valid, 1'b1);
      chk("grant_rdata", exp_d ? bus.d_rdata : bus.if_rdata, 16'h0F0F);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while D owns the port: silent abort, then IF is served normally.
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 16'h0300; bus.d_wdata = 16'h1111;
    @(negedge clk);
    wait_cs(ok);
    @(negedge clk);
    res = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    res = 1'b0;
    chk("midrst_mem_cs", bus.mem_cs, 1'b0);
    chk("midrst_mem_addr", bus.mem_addr, 16'h0);
    chk("midrst_mem_wdata", bus.mem_wdata, 16'h0);
    chk("midrst_rdata", {bus.if_rdata, bus.d_rdata}, 32'h0);
    chk("midrst_valid_err", {bus.if_valid, bus.d_valid, bus.if_err, bus.d_err}, 4'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.d_valid || bus.if_valid || bus.mem_cs) seen = 1'b1;
    end
    chk("midrst_quiet", seen, 1'b0);

    v = '{1'b0, 1'b1, 16'h0400, 16'h0000, 16'h4321, 1, 16'h4321, 1'b0};
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
